iir_biquad_seq: RTL
===================

# iir_biquad_seq

Sequencer that time-shares one `dsp48a1_inst` multiply-accumulate slice to compute a direct-form-I biquad, one 18-bit sample at a time. It accepts samples over a valid/ready handshake and holds the coefficients and the x/y history. It issues five back-to-back MAC operations to the DSP, then returns a rounded-down, saturated 18-bit result. It sits between the sample source and the audio output path, wherever an LPF/HPF stage is needed.

## Interface
- `DSP_LATENCY`, 3: cycles from an operation issued on `dsp_*` to that operation's result on `dsp_pout`.
- `COEF_FRAC`, 16: fractional bits of the coefficients (Q2.16).
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `sample_in` in 18 signed: input sample x[n].
- `sample_in_valid` in 1: sample offered.
- `sample_in_ready` out 1: high only in IDLE.
- `sample_out` out 18 signed: y[n], saturated.
- `sample_out_valid` out 1: one-cycle pulse with a new y[n].
- `sample_out_sat` out 1: pulses with `sample_out_valid` when y[n] was clamped.
- `coef_b0`, `coef_b1`, `coef_b2`, `coef_a1`, `coef_a2` in 18 signed each: coefficients, latched at sample accept.
- `clear_state` in 1: zero the history (x1, x2, y1, y2).
- `dsp_opmode_x` out 2: X mux select (00 zero, 01 M).
- `dsp_opmode_z` out 2: Z mux select (00 zero, 10 P).
- `dsp_postadd_sub` out 1: 1 makes the post-adder compute Z − X.
- `dsp_ain`, `dsp_bin` out 18 signed each: multiplier operands.
- `dsp_pout` in 48 signed: DSP P output.

## Operation
- The filter computes y[n] = b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- States:
  - IDLE: `sample_in_ready`=1. When `sample_in_valid` is high, latch x and all five coefficients, then go to ISSUE with tap=0.
  - ISSUE: one operation per cycle, tap 0..4.
    - tap0: (x, b0), X=01, Z=00, sub=0.
    - tap1: (x1, b1), X=01, Z=10, sub=0.
    - tap2: (x2, b2), X=01, Z=10, sub=0.
    - tap3: (y1, a1), X=01, Z=10, sub=1.
    - tap4: (y2, a2), X=01, Z=10, sub=1.
    - After tap4, go to WAIT.
  - WAIT: count DSP_LATENCY−1 cycles, then go to DONE.
  - DONE: capture `dsp_pout` and compute the result. Shift history: x2←x1, x1←x, y2←y1, y1←y. Return to IDLE.
- Outside ISSUE, `dsp_*` outputs are driven to 0 (X=00, Z=00, sub=0, ain=bin=0), which clears P.
- Result arithmetic:
  - s = `dsp_pout` >>> COEF_FRAC (arithmetic shift; truncation toward −∞).
  - If s > 131071, y = 131071 and `sample_out_sat`=1.
  - If s < −131072, y = −131072 and `sample_out_sat`=1.
  - Otherwise y = s[17:0].
- The history always stores the saturated y.
- `clear_state`:
  - In IDLE, it zeroes the history the next cycle. If a sample is accepted in the same cycle, that sample uses the zeroed history.
  - Outside IDLE, it is latched as pending. In DONE, the pending clear overrides the history update (all history becomes 0). The current y is still output, and the pending flag is cleared.
- `sample_in_valid` outside IDLE is ignored; the source must hold it until accepted.
- Coefficient changes take effect only at the next accept.

## Timing
- Accept at cycle T (valid & ready).
- ISSUE runs T+1..T+5.
- DONE is at cycle T+5+DSP_LATENCY.
- `sample_out`/`sample_out_valid` are registered: valid in cycle T+6+DSP_LATENCY for exactly 1 cycle.
- `sample_in_ready` returns high in the same cycle T+6+DSP_LATENCY. Minimum sample period is DSP_LATENCY+6 cycles (9 at default).
- `sample_out` holds its value between pulses.
- Reset values:
  - State IDLE; all history, latched coefficients, and the pending clear flag = 0.
  - `sample_in_ready`=1 in the first cycle after reset is released.
  - `sample_out`=0, `sample_out_valid`=0, `sample_out_sat`=0.
  - All `dsp_*` outputs = 0.
- Reset asserted mid-operation aborts immediately to the reset state. No `sample_out_valid` is produced for the aborted sample.

## Test plan
- Reset: assert `reset` during ISSUE → next cycle all outputs 0, ready=1. No out_valid follows. History is zero, so with b0=65536 and x=7 the next output is y=7.
- Passthrough: b0=65536, others 0, x=1000 → y=1000 at T+9. `dsp_opmode_x`=01 during T+1..T+5. Ready low T+1..T+8.
- FIR: b0=b1=b2=32768, a=0; impulse 1000, 0, 0, 0 → y = 500, 500, 500, 0.
- Feedback: b0=65536, a1=−32768, others 0; impulse 1000, then zeros → y = 1000, 500, 250, 125, 62. Sub=1 seen on taps 3–4.
- Saturation: b0=131071, x=131071 → y=131071 with sat=1. Then x=−131072 → y=−131072 with sat=1.
- Clear mid-operation: FIR setup; x=1000 accepted, `clear_state` pulsed at T+3 → y=500 is output. The next sample x=0 gives y=0.

Source files
------------

// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: direct-form-I biquad sequenced onto one external
// multiply-accumulate slice. Five MAC taps are issued back to back per
// sample. The accumulated P value is shifted down by COEF_FRAC, floored and
// saturated to 18 bits, then registered as y[n].
//
// Handshake: a sample transfers on a cycle where sample_in_valid and
// sample_in_ready are both high. Ready is high only in IDLE. The source
// holds valid (and data) until that transfer. sample_out_valid is a
// one-cycle pulse with no back-pressure.
//
// DSP_LATENCY must be at least 2, because WAIT lasts DSP_LATENCY-1 cycles.
module iir_biquad_seq #(
  parameter int DSP_LATENCY = 3,
  parameter int COEF_FRAC   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [17:0] sample_in,
  input  logic               sample_in_valid,
  output logic               sample_in_ready,
  output logic signed [17:0] sample_out,
  output logic               sample_out_valid,
  output logic               sample_out_sat,
  input  logic signed [17:0] coef_b0,
  input  logic signed [17:0] coef_b1,
  input  logic signed [17:0] coef_b2,
  input  logic signed [17:0] coef_a1,
  input  logic signed [17:0] coef_a2,
  input  logic               clear_state,
  output logic        [1:0]  dsp_opmode_x,
  output logic        [1:0]  dsp_opmode_z,
  output logic               dsp_postadd_sub,
  output logic signed [17:0] dsp_ain,
  output logic signed [17:0] dsp_bin,
  input  logic signed [47:0] dsp_pout,
  output logic        [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(DSP_LATENCY - 2);
  localparam logic signed [47:0] Y_MAX = 48'sd131071;
  localparam logic signed [47:0] Y_MIN = -48'sd131072;

  state_t state_q, state_d;
  logic [2:0] tap_q, tap_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic signed [17:0] x_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [17:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  logic               clr_pend_q;
  logic signed [17:0] out_q;
  logic               out_valid_q;
  logic               out_sat_q;

  logic signed [47:0] shifted;
  logic               sat_hi, sat_lo;
  logic signed [17:0] y_res;

  // State register for the sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tap_q   <= 3'd0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic: accept, five taps, drain the DSP pipeline, finish
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (sample_in_valid) begin
          state_d = S_ISSUE;
          tap_d   = 3'd0;
        end
      end
      S_ISSUE: begin
        if (tap_q == 3'd4) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd0;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: DSP operands per tap; all zero outside ISSUE so P clears
  always_comb begin
    sample_in_ready = (state_q == S_IDLE);
    dsp_opmode_x    = 2'b00;
    dsp_opmode_z    = 2'b00;
    dsp_postadd_sub = 1'b0;
    dsp_ain         = '0;
    dsp_bin         = '0;
    if (state_q == S_ISSUE) begin
      dsp_opmode_x = 2'b01;
      case (tap_q)
        3'd0: begin
          dsp_ain = x_q;
          dsp_bin = b0_q;
        end
        3'd1: begin
          dsp_ain      = x1_q;
          dsp_bin      = b1_q;
          dsp_opmode_z = 2'b10;
        end
        3'd2: begin
          dsp_ain      = x2_q;
          dsp_bin      = b2_q;
          dsp_opmode_z = 2'b10;
        end
        3'd3: begin
          dsp_ain         = y1_q;
          dsp_bin         = a1_q;
          dsp_opmode_z    = 2'b10;
          dsp_postadd_sub = 1'b1;
        end
        3'd4: begin
          dsp_ain         = y2_q;
          dsp_bin         = a2_q;
          dsp_opmode_z    = 2'b10;
          dsp_postadd_sub = 1'b1;
        end
        default: begin
          dsp_opmode_x = 2'b00;
        end
      endcase
    end
  end

  // Result scaling: arithmetic shift floors toward -inf, then clamp to 18 bits
  always_comb begin
    shifted = dsp_pout >>> COEF_FRAC;
    sat_hi  = (shifted > Y_MAX);
    sat_lo  = (shifted < Y_MIN);
    if (sat_hi) begin
      y_res = 18'sh1FFFF;
    end else if (sat_lo) begin
      y_res = 18'sh20000;
    end else begin
      y_res = shifted[17:0];
    end
  end

  // Datapath: sample/coefficient latch, history, pending clear, output register
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      clr_pend_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A clear here lands before tap1 reads history, so a sample
          // accepted in this same cycle already sees zeroed history.
          if (clear_state) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
          end
          if (sample_in_valid) begin
            x_q  <= sample_in;
            b0_q <= coef_b0;
            b1_q <= coef_b1;
            b2_q <= coef_b2;
            a1_q <= coef_a1;
            a2_q <= coef_a2;
          end
        end
        S_DONE: begin
          out_q       <= y_res;
          out_valid_q <= 1'b1;
          out_sat_q   <= sat_hi | sat_lo;
          if (clr_pend_q || clear_state) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
          end else begin
            x2_q <= x1_q;
            x1_q <= x_q;
            y2_q <= y1_q;
            y1_q <= y_res;
          end
          clr_pend_q <= 1'b0;
        end
        default: begin
          if (clear_state) clr_pend_q <= 1'b1;
        end
      endcase
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = out_valid_q;
  assign sample_out_sat   = out_sat_q;
  assign dbg_state_o      = state_q;

endmodule
